// File: rtl/conway_link_pkg.sv
// rtl/conway_link_pkg.sv - shared state encoding and opcodes for the serial grid link
package conway_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP,
        DRAIN,
        RESP
    } link_state_t;

    localparam logic OP_LOAD     = 1'b0;
    localparam logic OP_READBACK = 1'b1;

endpackage

// File: rtl/link_bit_counter.sv
// rtl/link_bit_counter.sv - bit-position up-counter with clear, enable and terminal flag at MAX-1
module link_bit_counter #(
    parameter int MAX = 64,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == W'(MAX - 1));

endmodule

// File: rtl/serial_grid_link.sv
// rtl/serial_grid_link.sv - host-side serial engine sequencing load/readback of the grid memory
module serial_grid_link
    import conway_link_pkg::*;
#(
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [DATA_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_op,
    output logic [DATA_SIZE-1:0] rsp_data,
    input  logic                 run_req,
    output logic                 run_mode,
    output logic                 load_mode,
    output logic                 output_mode,
    output logic                 serial_in,
    input  logic                 serial_out
);

    localparam int CW = $clog2(DATA_SIZE + 1);

    link_state_t          state_q;
    logic [DATA_SIZE-1:0] word_q;
    logic [DATA_SIZE-1:0] rx_q;
    logic                 op_q;
    logic [CW-1:0]        count;
    logic                 tc;
    logic                 shifting;
    logic [DATA_SIZE-1:0] word_aligned;

    assign shifting = (state_q == LOAD) || (state_q == DUMP);

    // Counter sits at zero whenever the FSM is not shifting, so LOAD/DUMP always start at bit 0.
    link_bit_counter #(
        .MAX (DATA_SIZE),
        .W   (CW)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (!shifting),
        .en_i    (shifting),
        .count_o (count),
        .tc_o    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            rx_q    <= '0;
            op_q    <= OP_LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        word_q  <= cmd_data;
                        op_q    <= cmd_op;
                        rx_q    <= '0;
                        state_q <= (cmd_op == OP_READBACK) ? DUMP : LOAD;
                    end
                end
                LOAD: begin
                    if (tc) state_q <= RESP;
                end
                DUMP: begin
                    // serial_out lags output_mode by one cycle; bit 0 of the dump is stale.
                    if (count != '0) rx_q <= {rx_q[DATA_SIZE-2:0], serial_out};
                    if (tc) state_q <= DRAIN;
                end
                DRAIN: begin
                    rx_q    <= {rx_q[DATA_SIZE-2:0], serial_out};
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_aligned = word_q << count;

    assign cmd_ready   = (state_q == IDLE) && !run_req;
    assign run_mode    = (state_q == IDLE) && run_req;
    assign load_mode   = (state_q == LOAD);
    assign output_mode = (state_q == DUMP);
    assign serial_in   = load_mode && word_aligned[DATA_SIZE-1];
    assign rsp_valid   = (state_q == RESP);
    assign rsp_op      = op_q;
    assign rsp_data    = (op_q == OP_READBACK) ? rx_q : word_q;

endmodule

// File: tb/tb_serial_grid_link.sv
// tb/tb_serial_grid_link.sv - randomized self-checking bench with a behavioural serial memory
module tb_serial_grid_link;

    logic clk;
    logic reset;

    logic       cmd_valid, cmd_ready, cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_op;
    logic [7:0] rsp_data;
    logic       run_req, run_mode, load_mode, output_mode, serial_in, serial_out;

    logic        cmd_valid64, cmd_ready64, cmd_op64;
    logic [63:0] cmd_data64;
    logic        rsp_valid64, rsp_ready64, rsp_op64;
    logic [63:0] rsp_data64;
    logic        run_req64, run_mode64, load_mode64, output_mode64, serial_in64, serial_out64;

    logic [7:0]  mem8;
    logic [63:0] mem64;

    int n_tests = 0;
    int n_fail  = 0;
    int excl_err = 0;

    serial_grid_link #(.DATA_SIZE(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .run_req(run_req), .run_mode(run_mode), .load_mode(load_mode),
        .output_mode(output_mode), .serial_in(serial_in), .serial_out(serial_out)
    );

    serial_grid_link #(.DATA_SIZE(64)) dut64 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid64), .cmd_ready(cmd_ready64), .cmd_op(cmd_op64), .cmd_data(cmd_data64),
        .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready64), .rsp_op(rsp_op64), .rsp_data(rsp_data64),
        .run_req(run_req64), .run_mode(run_mode64), .load_mode(load_mode64),
        .output_mode(output_mode64), .serial_in(serial_in64), .serial_out(serial_out64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the memory's serial port: shift in on load, shift out MSB-first on output.
    initial begin
        mem8 = '0; mem64 = '0; serial_out = 1'b0; serial_out64 = 1'b0;
    end
    always @(posedge clk) begin
        if (load_mode) mem8 <= {mem8[6:0], serial_in};
        else if (output_mode) begin
            serial_out <= mem8[7];
            mem8       <= {mem8[6:0], 1'b0};
        end
        if (load_mode64) mem64 <= {mem64[62:0], serial_in64};
        else if (output_mode64) begin
            serial_out64 <= mem64[63];
            mem64        <= {mem64[62:0], 1'b0};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (int'(load_mode) + int'(output_mode) + int'(run_mode) > 1) excl_err++;
            if (int'(load_mode64) + int'(output_mode64) + int'(run_mode64) > 1) excl_err++;
            if (!load_mode && serial_in) excl_err++;
            if (!load_mode64 && serial_in64) excl_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers a command and returns at the first falling edge after the acceptance edge.
    task automatic accept(input logic op, input logic [7:0] data);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 64'(t < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic op, input logic [7:0] data, input int hold,
                           output logic [7:0] got, output logic got_op, output int lat,
                           output int lcyc, output int ocyc, output logic [7:0] sin_bits,
                           output int err);
        lat = 1; lcyc = 0; ocyc = 0; sin_bits = '0; err = 0;
        accept(op, data);
        while (!rsp_valid && lat < 100) begin
            if (load_mode) begin
                lcyc++;
                sin_bits = {sin_bits[6:0], serial_in};
            end
            if (output_mode) ocyc++;
            if (cmd_ready) err++;
            @(negedge clk);
            lat++;
        end
        got = rsp_data; got_op = rsp_op;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== got || cmd_ready) err++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid) err++;
    endtask

    task automatic cmd64(input logic op, input logic [63:0] data, output logic [63:0] got,
                         output int lat);
        int t = 0;
        @(negedge clk);
        cmd_valid64 = 1'b1; cmd_op64 = op; cmd_data64 = data;
        while (!cmd_ready64 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept64_timeout", 64'(t < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid64 = 1'b0;
        lat = 1;
        while (!rsp_valid64 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = rsp_data64;
        rsp_ready64 = 1'b1;
        @(negedge clk);
        rsp_ready64 = 1'b0;
    endtask

    logic [7:0]  exp_mem;
    logic [7:0]  got, sin_bits, data;
    logic        got_op, op;
    int          lat, lcyc, ocyc, err, rm_err, hold;
    logic [63:0] got64;

    initial begin
        reset = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_data = '0; rsp_ready = 0; run_req = 0;
        cmd_valid64 = 0; cmd_op64 = 0; cmd_data64 = '0; rsp_ready64 = 0; run_req64 = 0;
        exp_mem = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_modes", {load_mode, output_mode, run_mode, serial_in}, 0);
        check("rst_rsp_data", rsp_data, 0);
        reset = 1'b0;

        run_cmd(1'b0, 8'hA5, 0, got, got_op, lat, lcyc, ocyc, sin_bits, err);
        check("a5_load_cycles", lcyc, 8);
        check("a5_serial_in", sin_bits, 8'hA5);
        check("a5_mem", mem8, 8'hA5);
        check("a5_rsp_data", got, 8'hA5);
        check("a5_rsp_op", got_op, 0);
        check("a5_latency", lat, 9);
        check("a5_handshake", err, 0);

        run_cmd(1'b0, 8'h3C, 0, got, got_op, lat, lcyc, ocyc, sin_bits, err);
        check("3c_mem", mem8, 8'h3C);
        run_cmd(1'b1, 8'h00, 5, got, got_op, lat, lcyc, ocyc, sin_bits, err);
        check("rb_output_cycles", ocyc, 8);
        check("rb_latency", lat, 10);
        check("rb_rsp_data", got, 8'h3C);
        check("rb_rsp_op", got_op, 1);
        check("rb_stall_stable", err, 0);
        check("rb_mem_cleared", mem8, 0);
        exp_mem = '0;

        @(negedge clk);
        run_req = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h11;
        #1;
        check("runreq_cmd_ready", cmd_ready, 0);
        check("runreq_run_mode", run_mode, 1);
        repeat (3) @(negedge clk);
        check("runreq_no_accept", {load_mode, output_mode, rsp_valid}, 0);
        cmd_valid = 1'b0; run_req = 1'b0;

        accept(1'b0, 8'h5A);
        run_req = 1'b1; rm_err = 0; lat = 0;
        while (!rsp_valid && lat < 50) begin
            if (run_mode) rm_err++;
            @(negedge clk);
            lat++;
        end
        check("busy_run_mode", rm_err, 0);
        check("busy_load_done", rsp_data, 8'h5A);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("busy_run_mode_idle", run_mode, 1);
        check("busy_mem", mem8, 8'h5A);
        run_req = 1'b0;
        exp_mem = 8'h5A;

        accept(1'b0, 8'hFF);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_modes", {load_mode, output_mode, run_mode}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;

        data = 8'($urandom);
        run_cmd(1'b0, data, 0, got, got_op, lat, lcyc, ocyc, sin_bits, err);
        check("post_rst_load", mem8, data);
        exp_mem = data;

        for (int i = 0; i < 16; i++) begin
            op   = 1'($urandom);
            data = 8'($urandom);
            hold = int'($urandom_range(0, 3));
            run_cmd(op, data, hold, got, got_op, lat, lcyc, ocyc, sin_bits, err);
            check("rnd_rsp_op", got_op, op);
            check("rnd_handshake", err, 0);
            if (op == 1'b0) begin
                check("rnd_load_data", got, data);
                check("rnd_load_bits", sin_bits, data);
                check("rnd_load_lat", lat, 9);
                exp_mem = data;
            end else begin
                check("rnd_rb_data", got, exp_mem);
                check("rnd_rb_lat", lat, 10);
                exp_mem = '0;
            end
            check("rnd_mem", mem8, exp_mem);
        end

        cmd64(1'b0, 64'h8000_0000_0000_0001, got64, lat);
        check("w64_load_lat", lat, 65);
        check("w64_mem", mem64, 64'h8000_0000_0000_0001);
        cmd64(1'b1, 64'h0, got64, lat);
        check("w64_rb_data", got64, 64'h8000_0000_0000_0001);
        check("w64_rb_lat", lat, 66);

        check("mode_exclusive", excl_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
